inst_buffer: RTL

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/inst_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : inst_buffer                                                       |
// | Brief  : Circular instruction FIFO between fetch and decode with squash.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  input  logic [XLEN-1:0]            in_PC,
  input  logic [XLEN-1:0]            in_NPC,
  output logic                       fetch_en,
  input  logic                       deq_ready,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_PC,
  output logic [XLEN-1:0]            out_NPC,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  logic [31:0]       r_inst_mem [DEPTH];
  logic [XLEN-1:0]   r_pc_mem   [DEPTH];
  logic [XLEN-1:0]   r_npc_mem  [DEPTH];

  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic               w_not_full;
  logic               w_not_empty;
  logic               w_enq;
  logic               w_deq;
  logic [c_PTR_W-1:0] w_head_next;
  logic [c_PTR_W-1:0] w_tail_next;

  // Space/occupancy flags look only at the count register so fetch_en never
  // depends combinationally on this cycle's inputs.
  assign w_not_full  = (r_count != c_FULL_CNT);
  assign w_not_empty = (r_count != '0);

  assign w_enq = in_valid && w_not_full && !squash;
  assign w_deq = w_not_empty && deq_ready && !squash;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  assign w_head_next = (r_head == c_LAST_IDX) ? '0 : r_head + c_PTR_W'(1);
  assign w_tail_next = (r_tail == c_LAST_IDX) ? '0 : r_tail + c_PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= w_tail_next;
      if (w_deq) r_head <= w_head_next;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is never reset; it is masked at the outputs while empty.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_inst_mem[r_tail] <= in_inst;
      r_pc_mem[r_tail]   <= in_PC;
      r_npc_mem[r_tail]  <= in_NPC;
    end
  end

  assign fetch_en  = w_not_full;
  assign out_valid = w_not_empty;
  assign out_inst  = w_not_empty ? r_inst_mem[r_head] : '0;
  assign out_PC    = w_not_empty ? r_pc_mem[r_head]   : '0;
  assign out_NPC   = w_not_empty ? r_npc_mem[r_head]  : '0;
  assign count     = r_count;

endmodule
`default_nettype wire
